// File: rtl/max_track_pkg.sv
// Shared types and constants for the frame maximum tracker.
// Holds the FSM state encoding and counter sizing used by max_track_4.
package max_track_pkg;

  localparam int CNT_W             = 4;
  localparam int FRAME_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // A frame is in flight from its first accepted sample until its result is taken.
  function automatic logic state_busy(input state_e st);
    return (st == ST_ACCUM) || (st == ST_DONE);
  endfunction

  // Only IDLE and ACCUM may take a sample.
  function automatic logic state_takes_sample(input state_e st);
    return (st == ST_IDLE) || (st == ST_ACCUM);
  endfunction

endpackage

// File: rtl/gt_4.sv
// 4-bit unsigned strict greater-than comparator: y = (a > b).
module gt_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       y
);

  assign y = (a > b);

endmodule

// File: rtl/max_track_4.sv
// Per-frame maximum tracker: reports the largest sample of each FRAME_LEN-sample
// frame and the position of its first occurrence, with valid/ready handshakes.
module max_track_4
  import max_track_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [3:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [3:0] m_max,
  output logic [3:0] m_idx,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_max;
  logic [3:0]       w_max_nxt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_update;
  logic             w_s_acc;
  logic             w_m_acc;

  gt_4 u_gt (
    .a (s_data),
    .b (r_max),
    .y (w_update)
  );

  // Handshake flags come from the state register alone, never from s_valid/m_ready.
  assign s_ready = state_takes_sample(r_state);
  assign m_valid = (r_state == ST_DONE);
  assign busy    = state_busy(r_state);
  assign m_max   = r_max;
  assign m_idx   = r_idx;

  assign w_s_acc = s_valid & s_ready;
  assign w_m_acc = m_valid & m_ready;

  // Next-state and datapath update decode.
  always_comb begin
    w_state_nxt = r_state;
    w_max_nxt   = r_max;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s_acc) begin
          w_max_nxt   = s_data;
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_s_acc) begin
          // Strict compare: a tie keeps the earlier index.
          if (w_update) begin
            w_max_nxt = s_data;
            w_idx_nxt = r_cnt;
          end else begin
            w_max_nxt = r_max;
            w_idx_nxt = r_idx;
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (w_m_acc) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_max_nxt   = 4'd0;
        w_idx_nxt   = 4'd0;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running maximum, its index and the in-frame sample counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max <= 4'd0;
      r_idx <= 4'd0;
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_max <= w_max_nxt;
      r_idx <= w_idx_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_max_track_4.sv
// Self-checking bench for max_track_4 (FRAME_LEN=8): directed scenarios plus
// randomized frames compared against a simple array-based reference.
module tb_max_track_4;

  localparam int FL = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_max;
  logic [3:0] m_idx;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int frame_v[FL];

  always #5 clk = ~clk;

  max_track_4 #(.FRAME_LEN(FL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_max   (m_max),
    .m_idx   (m_idx),
    .busy    (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: largest value, then the first position holding it.
  task automatic ref_result(output int mx, output int ix);
    mx = 0;
    for (int i = 0; i < FL; i++) if (frame_v[i] > mx) mx = frame_v[i];
    ix = -1;
    for (int i = 0; i < FL; i++) if (frame_v[i] == mx && ix < 0) ix = i;
  endtask

  // gap_mode: 0 none, 1 one idle cycle after each sample, 2 random 0..2 idle cycles.
  task automatic run_frame(input string tag, input int gap_mode, input int hold);
    int mx;
    int ix;
    int g;
    ref_result(mx, ix);
    m_ready = (hold == 0);
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0)
        begin failures++; $display("FAIL %s ready_before_sample%0d got s_ready=%b m_valid=%b exp 1 0", tag, i, s_ready, m_valid); end
      s_valid = 1'b1;
      s_data  = 4'(frame_v[i]);
      tick();
      if (i < FL - 1) begin
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b1)
          begin failures++; $display("FAIL %s accum%0d got m_valid=%b busy=%b exp 0 1", tag, i, m_valid, busy); end
        g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int k = 0; k < g; k++) begin
          s_valid = 1'b0;
          s_data  = 4'($urandom);
          tick();
          checks++;
          if (busy !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b1)
            begin failures++; $display("FAIL %s gap%0d got busy=%b m_valid=%b s_ready=%b exp 1 0 1", tag, i, busy, m_valid, s_ready); end
        end
      end
    end
    // Offer a dominating junk sample during DONE; it must never be taken.
    s_valid = 1'b1;
    s_data  = 4'hF;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1)
      begin failures++; $display("FAIL %s done_flags got m_valid=%b s_ready=%b busy=%b exp 1 0 1", tag, m_valid, s_ready, busy); end
    checks++;
    if (m_max !== 4'(mx) || m_idx !== 4'(ix))
      begin failures++; $display("FAIL %s result got max=%0d idx=%0d exp max=%0d idx=%0d", tag, m_max, m_idx, mx, ix); end
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_max !== 4'(mx) || m_idx !== 4'(ix))
        begin failures++; $display("FAIL %s hold%0d got m_valid=%b s_ready=%b max=%0d idx=%0d exp 1 0 %0d %0d", tag, k, m_valid, s_ready, m_max, m_idx, mx, ix); end
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL %s release got m_valid=%b s_ready=%b busy=%b exp 0 1 0", tag, m_valid, s_ready, busy); end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 4'd0;
    m_ready = 1'b0;
    #3;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_max !== 4'd0 || m_idx !== 4'd0)
      begin failures++; $display("FAIL reset got s_ready=%b m_valid=%b busy=%b max=%0d idx=%0d exp 1 0 0 0 0", s_ready, m_valid, busy, m_max, m_idx); end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int v[FL] = '{3, 7, 2, 9, 9, 1, 0, 4};
    frame_v = v;
    run_frame("basic", 0, 0);
  endtask

  task automatic test_ties();
    for (int i = 0; i < FL; i++) frame_v[i] = 5;
    run_frame("all_equal", 0, 0);
    for (int i = 0; i < FL; i++) frame_v[i] = 0;
    frame_v[0] = 15;
    frame_v[FL-1] = 15;
    run_frame("edge_15", 0, 0);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < FL; i++) frame_v[i] = i;
    run_frame("ascending_gaps", 1, 0);
  endtask

  task automatic test_backpressure();
    int v[FL] = '{2, 11, 4, 11, 0, 6, 8, 1};
    frame_v = v;
    run_frame("backpressure", 0, 5);
    // Small values after the held frame: a stray accept of 15 would show up.
    for (int i = 0; i < FL; i++) frame_v[i] = (i == 2) ? 3 : 1;
    run_frame("after_release", 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int part[4] = '{1, 14, 2, 3};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 4'(part[i]);
      tick();
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_max !== 4'd0 || m_idx !== 4'd0)
      begin failures++; $display("FAIL mid_reset got s_ready=%b m_valid=%b busy=%b max=%0d idx=%0d exp 1 0 0 0 0", s_ready, m_valid, busy, m_max, m_idx); end
    #2;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < FL; i++) frame_v[i] = 4;
    frame_v[FL-1] = 6;
    run_frame("post_reset", 0, 0);
  endtask

  task automatic test_reset_in_done();
    m_ready = 1'b0;
    for (int i = 0; i < FL; i++) begin
      s_valid = 1'b1;
      s_data  = 4'(12 + (i % 3));
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1)
      begin failures++; $display("FAIL done_before_reset got m_valid=%b exp 1", m_valid); end
    reset_n = 1'b0;
    #2;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1)
      begin failures++; $display("FAIL done_reset got m_valid=%b busy=%b s_ready=%b exp 0 0 1", m_valid, busy, s_ready); end
    #2;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < FL; i++) frame_v[i] = 2;
    frame_v[5] = 9;
    run_frame("after_done_reset", 0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < FL; i++)
        frame_v[i] = (f % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      run_frame($sformatf("random%0d", f), 2, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_gaps();
    test_backpressure();
    test_reset_mid_frame();
    test_reset_in_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
